// File: rtl/up_heartbeat_arb_pkg.sv
// Shared types and type codes for the upstream heartbeat/BD arbiter.
// Upstream words are {code, payload}: BD words use code 0, heartbeats use a HI/LO pair.
package up_pkg;

    localparam logic [3:0] BD_CODE    = 4'h0;
    localparam logic [3:0] HB_LO_CODE = 4'hE;
    localparam logic [3:0] HB_HI_CODE = 4'hF;

    typedef enum logic {
        IDLE_BD    = 1'b0,
        HB_LO_NEXT = 1'b1
    } up_arb_state_t;

    typedef enum logic {
        GRANT_BD = 1'b0,
        GRANT_HB = 1'b1
    } up_grant_t;

    typedef struct packed {
        logic [3:0]  code;
        logic [19:0] payload;
    } up_word_t;

    function automatic up_word_t make_word(input logic [3:0] code, input logic [19:0] payload);
        up_word_t w;
        w.code    = code;
        w.payload = payload;
        return w;
    endfunction

endpackage

// File: rtl/up_heartbeat_arb_pending.sv
// Captures the latest heartbeat time, clears it on launch, and flags
// any heartbeat that was overwritten before it could be sent.
module hb_pending_reg #(
    parameter int Ntime = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hb_en,
    input  logic             epoch_tick,
    input  logic [Ntime-1:0] epochs_elapsed,
    input  logic             launch,
    output logic [Ntime-1:0] pend_time,
    output logic             hb_pending,
    output logic             hb_coalesced
);

    logic tick_s;

    assign tick_s = epoch_tick & hb_en;

    // A tick in the launch cycle re-arms with the new time; that is not a coalesce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_time    <= '0;
            hb_pending   <= 1'b0;
            hb_coalesced <= 1'b0;
        end else if (tick_s) begin
            pend_time  <= epochs_elapsed;
            hb_pending <= 1'b1;
            if (hb_pending && !launch) begin
                hb_coalesced <= 1'b1;
            end
        end else if (launch) begin
            hb_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/up_heartbeat_arb.sv
// Round-robin scheduler of BD words and two-word heartbeat packets onto
// the single upstream link, with a one-entry registered output stage.
import up_pkg::*;

module up_heartbeat_arb #(
    parameter  int Ntime = 32,
    parameter  int Nbd   = 20,
    parameter  int Ncode = 4,
    localparam int Nout  = Ncode + Nbd
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hb_en,
    input  logic             epoch_tick,
    input  logic [Ntime-1:0] epochs_elapsed,
    input  logic             bd_v,
    input  logic [Nbd-1:0]   bd_d,
    output logic             bd_a,
    output logic             up_v,
    output logic [Nout-1:0]  up_d,
    input  logic             up_a,
    output logic             hb_coalesced
);

    logic             load_ok_s;
    logic             launch_s;
    logic             bd_a_s;
    logic             hb_pending_s;
    logic [Ntime-1:0] pend_time_s;
    logic [19:0]      hi_payload_s;
    // Only the low 20 bits of the launched time are needed later (for LO);
    // HI is built directly from pend_time in the launch cycle.
    logic [19:0]      snap_lo_r;
    up_arb_state_t    state_r, state_nxt_s;
    up_grant_t        grant_r, grant_nxt_s;
    logic             up_v_r, up_v_nxt_s;
    up_word_t         up_d_r, word_nxt_s;

    hb_pending_reg #(.Ntime(Ntime)) u_pending (
        .clk            (clk),
        .reset          (reset),
        .hb_en          (hb_en),
        .epoch_tick     (epoch_tick),
        .epochs_elapsed (epochs_elapsed),
        .launch         (launch_s),
        .pend_time      (pend_time_s),
        .hb_pending     (hb_pending_s),
        .hb_coalesced   (hb_coalesced)
    );

    assign load_ok_s    = ~up_v_r | up_a;
    assign hi_payload_s = 20'(pend_time_s[Ntime-1:20]);

    // Choose the next content of the output register when it may be loaded.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        up_v_nxt_s  = up_v_r;
        word_nxt_s  = up_d_r;
        launch_s    = 1'b0;
        bd_a_s      = 1'b0;
        if (load_ok_s) begin
            case (state_r)
                IDLE_BD: begin
                    if (hb_pending_s && ((grant_r == GRANT_BD) || !bd_v)) begin
                        up_v_nxt_s  = 1'b1;
                        word_nxt_s  = make_word(HB_HI_CODE, hi_payload_s);
                        launch_s    = 1'b1;
                        state_nxt_s = HB_LO_NEXT;
                    end else if (bd_v) begin
                        up_v_nxt_s  = 1'b1;
                        word_nxt_s  = make_word(BD_CODE, bd_d);
                        bd_a_s      = 1'b1;
                        grant_nxt_s = GRANT_BD;
                    end else begin
                        up_v_nxt_s  = 1'b0;
                    end
                end
                HB_LO_NEXT: begin
                    up_v_nxt_s  = 1'b1;
                    word_nxt_s  = make_word(HB_LO_CODE, snap_lo_r);
                    grant_nxt_s = GRANT_HB;
                    state_nxt_s = IDLE_BD;
                end
                default: begin
                    up_v_nxt_s  = 1'b0;
                    state_nxt_s = IDLE_BD;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Arbiter state, output register and launched-heartbeat snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE_BD;
            grant_r   <= GRANT_BD;
            up_v_r    <= 1'b0;
            up_d_r    <= '0;
            snap_lo_r <= 20'h00000;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            up_v_r  <= up_v_nxt_s;
            up_d_r  <= word_nxt_s;
            if (launch_s) begin
                snap_lo_r <= pend_time_s[19:0];
            end
        end
    end

    assign bd_a = bd_a_s & ~reset;
    assign up_v = up_v_r;
    assign up_d = up_d_r;

endmodule
